// File: rtl/raccoon_pkg.sv
// Raccoon ring packet layout and helpers shared by every ring node.
// Field widths, packet struct, empty slot constant, bridge states.
package raccoon_pkg;

  localparam int PKT_W  = 80;
  localparam int MASK_W = 4;
  localparam int TAG_W  = 9;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int VALID_BIT = 79;
  localparam int RESP_BIT  = 78;
  localparam int WE_BIT    = 77;
  localparam int MASK_LSB  = 73;
  localparam int TAG_LSB   = 64;
  localparam int ADDR_LSB  = 32;
  localparam int DATA_LSB  = 0;

  typedef struct packed {
    logic              valid;
    logic              resp;
    logic              we;
    logic [MASK_W-1:0] mask;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } racc_pkt_t;

  localparam racc_pkt_t EMPTY_SLOT = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDWAIT,
    ST_RESPOND
  } racc_state_t;

  // Turn a captured request into its response packet.
  function automatic racc_pkt_t racc_resp(
    input racc_pkt_t         req,
    input logic [DATA_W-1:0] d
  );
    racc_pkt_t p;
    p       = req;
    p.valid = 1'b1;
    p.resp  = 1'b1;
    p.data  = d;
    return p;
  endfunction

endpackage

// File: rtl/racc_ram.sv
// racc_ram: byte-masked synchronous single-port RAM for Raccoon systems.
// Ports: CLK, ADDR (word = ADDR[..:2]), CS, WR, MASK, DIN, DOUT (registered).
module racc_ram #(
  parameter int DEPTH_WORDS = 16384
) (
  input  logic        CLK,
  input  logic [31:0] ADDR,
  input  logic        CS,
  input  logic        WR,
  input  logic [3:0]  MASK,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_dout;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = ADDR[AW+1:2];
  assign w_unused = ^{ADDR[31:AW+2], ADDR[1:0]};
  assign DOUT     = r_dout;

  always_ff @(posedge CLK) begin
    if (CS && WR) begin
      for (int b = 0; b < 4; b++) begin
        if (MASK[b]) r_mem[w_idx][8*b +: 8] <= DIN[8*b +: 8];
      end
    end
    if (CS && !WR) r_dout <= r_mem[w_idx];
  end

endmodule

// File: rtl/raccoon2ram_wait.sv
// raccoon2ram_wait: Raccoon ring slave bridge onto a RAM port with WAIT.
// Ports: CLK, RST(async low), RaccIn/RaccOut, CS WE ADDR MASK WR_DATA WAIT RD_DATA.
module raccoon2ram_wait
  import raccoon_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_MASK = 32'hFFFF0000,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 32'hE0000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PKT_W-1:0]  RaccIn,
  output logic [PKT_W-1:0]  RaccOut,
  output logic              CS,
  input  logic              WAIT,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [MASK_W-1:0] MASK,
  output logic [DATA_W-1:0] WR_DATA,
  input  logic [DATA_W-1:0] RD_DATA
);

  racc_state_t       r_state;
  racc_pkt_t         r_req;
  racc_pkt_t         r_out;
  logic              r_cs;
  logic [DATA_W-1:0] r_rdata;

  racc_pkt_t         w_in;
  logic              w_hit;
  logic              w_free;
  logic [DATA_W-1:0] w_rd_now;

  assign w_in   = racc_pkt_t'(RaccIn);
  assign w_free = ~RaccIn[VALID_BIT];
  assign w_hit  = w_in.valid & ~w_in.resp &
                  ((w_in.addr & ADDR_MASK) == ADDR_BASE);

  // Writes echo their own data; reads take the RAM word now valid.
  assign w_rd_now = r_req.we ? r_req.data : RD_DATA;

  assign RaccOut = r_out;
  assign CS      = r_cs;
  assign WE      = r_req.we;
  assign ADDR    = r_req.addr;
  assign MASK    = r_req.mask;
  assign WR_DATA = r_req.data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_req   <= EMPTY_SLOT;
      r_out   <= EMPTY_SLOT;
      r_cs    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_out <= w_in;
      unique case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_req   <= w_in;
            r_cs    <= 1'b1;
            r_out   <= EMPTY_SLOT;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!WAIT) begin
            r_cs    <= 1'b0;
            r_state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          r_rdata <= w_rd_now;
          if (w_free) begin
            r_out   <= racc_resp(r_req, w_rd_now);
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (w_free) begin
            r_out   <= racc_resp(r_req, r_rdata);
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raccoon2ram_wait.sv
// Bench for raccoon2ram_wait with a racc_ram behind it.
// Directed steps plus randomized transactions against a memory model.
module tb_raccoon2ram_wait;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [79:0] RaccIn = '0;
  logic [79:0] RaccOut;
  logic        CS;
  logic        WAIT = 1'b0;
  logic        WE;
  logic [31:0] ADDR;
  logic [3:0]  MASK;
  logic [31:0] WR_DATA;
  logic [31:0] RD_DATA;

  int tests = 0;
  int fails = 0;
  bit [31:0] mdl [int];

  always #5 CLK = ~CLK;

  raccoon2ram_wait #(
    .ADDR_MASK(32'hFFFF0000),
    .ADDR_BASE(32'hE0000000)
  ) dut (
    .CLK(CLK), .RST(RST), .RaccIn(RaccIn), .RaccOut(RaccOut),
    .CS(CS), .WAIT(WAIT), .WE(WE), .ADDR(ADDR), .MASK(MASK),
    .WR_DATA(WR_DATA), .RD_DATA(RD_DATA)
  );

  racc_ram #(.DEPTH_WORDS(16384)) ram (
    .CLK(CLK), .ADDR(ADDR), .CS(CS), .WR(WE), .MASK(MASK),
    .DIN(WR_DATA), .DOUT(RD_DATA)
  );

  function automatic logic [79:0] mk(
    input bit v, input bit r, input bit w, input logic [3:0] m,
    input logic [8:0] t, input logic [31:0] a, input logic [31:0] d
  );
    return {v, r, w, m, t, a, d};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind 0 empty, 1 hit request, 2 out-of-window request, 3 response
  function automatic logic [79:0] other(input int kind);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [8:0]  t;
    bit          w;
    a = $urandom; d = $urandom;
    m = 4'($urandom); t = 9'($urandom); w = 1'($urandom);
    case (kind)
      0: return '0;
      1: return mk(1, 0, w, m, t, {16'hE000, a[15:0]}, d);
      2: begin
        if (a[31:16] == 16'hE000) a[31:16] = 16'hE001;
        return mk(1, 0, w, m, t, a, d);
      end
      default: return mk(1, 1, w, m, t, a, d);
    endcase
  endfunction

  // One request through the bridge. Cycle k is sampled at edge k.
  // Request at edge 0, nw WAIT cycles, then nb occupied slots
  // before the first empty one, so the response follows edge 2+nw+nb.
  task automatic txn(input string tag, input bit we, input logic [3:0] m,
                     input logic [8:0] t, input logic [31:0] a,
                     input logic [31:0] d, input int nw, input int nb,
                     output logic [79:0] got);
    logic [79:0] req, rsp, drv, exp;
    logic [31:0] w, rdat;
    int key, rcyc;
    bit ecs;
    key = int'(a[15:2]);
    req = mk(1, 0, we, m, t, a, d);
    if (we) begin
      w = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[key] = w;
      rdat = d;
    end else begin
      rdat = mdl[key];
    end
    rsp  = mk(1, 1, we, m, t, a, rdat);
    rcyc = 2 + nw + nb;
    got  = '0;
    for (int k = 0; k <= rcyc; k++) begin
      if (k == 0) drv = req;
      else if (k == 1) drv = other(1);
      else if (k <= 1 + nw) drv = other($urandom_range(0, 3));
      else if (k < rcyc) drv = other($urandom_range(1, 3));
      else drv = '0;
      RaccIn = drv;
      if (k >= 1 && k <= nw) WAIT = 1'b1;
      else if (k == nw + 1) WAIT = 1'b0;
      else WAIT = 1'($urandom);
      @(posedge CLK); #1;
      exp = (k == 0) ? 80'h0 : (k == rcyc) ? rsp : drv;
      chk($sformatf("%s out[%0d]", tag, k), RaccOut, exp);
      if (k == rcyc) got = RaccOut;
      ecs = (k <= nw);
      chk($sformatf("%s cs[%0d]", tag, k), 80'(CS), 80'(ecs));
      if (ecs)
        chk($sformatf("%s bus[%0d]", tag, k),
            80'({WE, MASK, ADDR, WR_DATA}), 80'({we, m, a, d}));
    end
    RaccIn = '0;
    WAIT = 1'b0;
  endtask

  task automatic pass(input string tag, input logic [79:0] p);
    RaccIn = p;
    WAIT = 1'($urandom);
    @(posedge CLK); #1;
    chk(tag, RaccOut, p);
    chk({tag, " cs"}, 80'(CS), 80'(0));
    RaccIn = '0;
    WAIT = 1'b0;
  endtask

  function automatic logic [31:0] slot_addr(input int i);
    if (i == 7) return 32'hE000FFFC;
    return 32'hE0000100 + 32'(i * 4);
  endfunction

  initial begin
    logic [79:0] got;
    logic [31:0] a;
    int s;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst state", {RaccOut}, 80'h0);
    chk("rst bus", 80'({CS, WE, MASK, ADDR, WR_DATA}), 80'h0);
    RST = 1'b1;

    pass("pass nonhit", mk(1, 0, 1, 4'hF, 9'h12, 32'hE0010000, 32'h5A5A5A5A));
    pass("pass resp", mk(1, 1, 0, 4'hF, 9'h07, 32'hE0000010, 32'h01020304));
    pass("pass empty", 80'h0);

    for (int i = 0; i < 8; i++)
      txn("pre", 1, 4'hF, 9'(i), slot_addr(i), $urandom, 0, 0, got);

    txn("wr deadbeef", 1, 4'hF, 9'd5, 32'hE0000010, 32'hDEADBEEF, 0, 0, got);
    txn("rd deadbeef", 0, 4'hF, 9'd5, 32'hE0000010, 32'h0, 0, 0, got);
    chk("rd deadbeef data", 80'(got[31:0]), 80'(32'hDEADBEEF));

    txn("wr base", 1, 4'hF, 9'd9, 32'hE0000020, 32'h11223344, 0, 0, got);
    txn("wr masked", 1, 4'b0010, 9'd9, 32'hE0000020, 32'h0000AA00, 0, 0, got);
    txn("rd masked", 0, 4'b0001, 9'd9, 32'hE0000020, 32'h0, 0, 0, got);
    chk("rd masked data", 80'(got[31:0]), 80'(32'h1122AA44));

    txn("wait6", 0, 4'hF, 9'd3, 32'hE0000010, 32'h0, 6, 0, got);
    txn("busy3", 0, 4'hF, 9'd4, 32'hE0000020, 32'h0, 0, 3, got);

    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 7);
      a = slot_addr(s) | 32'($urandom_range(0, 3));
      txn($sformatf("rnd%0d", n), 1'($urandom), 4'($urandom), 9'($urandom),
          a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    RaccIn = mk(1, 0, 0, 4'hF, 9'h33, 32'hE0000010, 32'h0);
    WAIT = 1'b1;
    @(posedge CLK); #1;
    RaccIn = '0;
    chk("rst mid cs", 80'(CS), 80'(1));
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    chk("rst mid out", RaccOut, 80'h0);
    chk("rst mid bus", 80'({CS, WE, MASK, ADDR, WR_DATA}), 80'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    WAIT = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("post rst out[%0d]", k), RaccOut, 80'h0);
      chk($sformatf("post rst cs[%0d]", k), 80'(CS), 80'(0));
    end

    pass("after rst pass", mk(1, 0, 0, 4'h3, 9'h1, 32'h12345678, 32'h9));
    txn("after rst rd", 0, 4'hF, 9'd6, 32'hE0000010, 32'h0, 1, 1, got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
